// File: rtl/bitwise_reduce_unit.sv
// Folds a burst of len operands into one WIDTH-bit result using AND/OR/XOR/NAND.
// Operands and the result each move over a valid/ready stream; all outputs are registered.
module bitwise_reduce_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [CNT_W-1:0] len,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             busy
);

    localparam logic [1:0]       OP_AND  = 2'b00;
    localparam logic [1:0]       OP_OR   = 2'b01;
    localparam logic [1:0]       OP_XOR  = 2'b10;
    localparam logic [1:0]       OP_NAND = 2'b11;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [CNT_W-1:0] len_q, len_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;

    logic             beat;
    logic             last_beat;
    logic             burst_go;
    logic [WIDTH-1:0] acc_fold;

    // NAND accumulates as AND; the inversion is applied only to the final result.
    function automatic logic [WIDTH-1:0] fold(input logic [1:0] o,
                                              input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
        case (o)
            OP_OR:   fold = a | b;
            OP_XOR:  fold = a ^ b;
            default: fold = a & b;
        endcase
    endfunction

    assign beat      = in_valid && in_ready_q;
    assign last_beat = beat && (cnt_q == (len_q - CNT_ONE));
    assign burst_go  = start && (len != '0);
    assign acc_fold  = fold(op_q, acc_q, in_data);

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (burst_go) state_d = ST_ACCUM;
            ST_ACCUM: if (last_beat) state_d = ST_DONE;
            ST_DONE:  if (out_valid_q && out_ready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Output decode from the upcoming state so the flops below track the state register
    always_comb begin
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
        case (state_d)
            ST_ACCUM: begin
                in_ready_d = 1'b1;
                busy_d     = 1'b1;
            end
            ST_DONE: begin
                out_valid_d = 1'b1;
                busy_d      = 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath next-state: burst setup, accumulation and result capture
    always_comb begin
        op_d       = op_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        out_data_d = out_data_q;
        case (state_q)
            ST_IDLE: begin
                if (burst_go) begin
                    op_d  = op;
                    len_d = len;
                    cnt_d = '0;
                    acc_d = ((op == OP_AND) || (op == OP_NAND)) ? '1 : '0;
                end
            end
            ST_ACCUM: begin
                if (beat) begin
                    acc_d = acc_fold;
                    cnt_d = cnt_q + CNT_ONE;
                    if (last_beat)
                        out_data_d = (op_q == OP_NAND) ? ~acc_fold : acc_fold;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q        <= OP_AND;
            len_q       <= '0;
            cnt_q       <= '0;
            acc_q       <= '0;
            out_data_q  <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            op_q        <= op_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            out_data_q  <= out_data_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign busy      = busy_q;

endmodule
